// File: rtl/axi_stream_strip_header.sv
// ---------------------------------------------------------------------------
// axi_stream_strip_header
//
// Removes a per-packet programmable number of leading bytes (S) from an
// AXI-Stream packet and realigns the remaining payload into full MSB-first
// beats. Byte 0 of a beat is data[DATA_WD-1 -: 8] and maps to keep[BYTES-1];
// keep is always contiguous from the MSB.
//
// Ports
//   clk, rstn                      single clock, synchronous active-low reset
//   valid_in/data_in/keep_in/last_in/ready_in
//                                  input stream (keep all-ones except on last)
//   valid_strip/strip_cnt/ready_strip
//                                  one strip-length command per packet
//   valid_out/data_out/keep_out/last_out/ready_out
//                                  registered, realigned output stream
//   short_pkt                      one-cycle pulse when a packet held <= S
//                                  bytes and therefore produced no output
//
// Optional feature (macro HDR_EXTRACT_EN)
//   When defined, hdr_valid/hdr_data/hdr_keep expose the stripped bytes of
//   each packet, MSB-aligned, one cycle after the first beat is accepted.
//   When undefined those ports do not exist and the stripped bytes are lost.
// ---------------------------------------------------------------------------
module axi_stream_strip_header #(
  parameter  int DATA_WD     = 32,
  localparam int BYTES       = DATA_WD / 8,
  localparam int BYTE_CNT_WD = $clog2(BYTES)
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   valid_in,
  input  logic [DATA_WD-1:0]     data_in,
  input  logic [BYTES-1:0]       keep_in,
  input  logic                   last_in,
  output logic                   ready_in,
  input  logic                   valid_strip,
  input  logic [BYTE_CNT_WD-1:0] strip_cnt,
  output logic                   ready_strip,
  output logic                   valid_out,
  output logic [DATA_WD-1:0]     data_out,
  output logic [BYTES-1:0]       keep_out,
  output logic                   last_out,
  input  logic                   ready_out,
  output logic                   short_pkt
`ifdef HDR_EXTRACT_EN
  ,
  output logic                   hdr_valid,
  output logic [DATA_WD-1:0]     hdr_data,
  output logic [BYTES-1:0]       hdr_keep
`endif
);

  // Shift amounts must be able to express a full beat (DATA_WD bits or
  // BYTES bytes) so that S=0 shifts the incoming beat completely away.
  localparam int SH_WD = $clog2(DATA_WD) + 1;
  localparam int CW    = BYTE_CNT_WD + 1;

  typedef enum logic [1:0] {
    IDLE,
    FIRST,
    BODY,
    FLUSH
  } state_t;

  state_t                 state, state_nxt;
  logic [BYTE_CNT_WD-1:0] strip_q, strip_nxt;
  logic [DATA_WD-1:0]     prev_data, prev_data_nxt;
  logic [BYTES-1:0]       prev_keep, prev_keep_nxt;

  logic                   valid_nxt;
  logic [DATA_WD-1:0]     data_nxt;
  logic [BYTES-1:0]       keep_nxt;
  logic                   last_nxt;
  logic                   short_nxt;

  logic                   adv;
  logic                   beat_acc;
  logic                   n_gt_s;
  logic [DATA_WD-1:0]     data_in_m;
  logic [SH_WD-1:0]       head_shift;
  logic [SH_WD-1:0]       tail_shift;
  logic [CW-1:0]          tail_cnt;
  logic [BYTES-1:0]       keep_in_sh;
  logic [DATA_WD-1:0]     body_data;
  logic [BYTES-1:0]       body_keep;

  // Expands a byte-enable vector into a bit mask over the data word.
  function automatic logic [DATA_WD-1:0] byte_mask(input logic [BYTES-1:0] keep);
    logic [DATA_WD-1:0] mask;
    mask = '0;
    for (int i = 0; i < BYTES; i++) begin
      mask[i*8 +: 8] = {8{keep[i]}};
    end
    return mask;
  endfunction

  // The output register may load a new beat whenever it is empty or the
  // current beat is being taken this cycle. Both ready signals are masked
  // while reset is held so nothing is handed over during reset.
  assign adv         = !valid_out || ready_out;
  assign ready_in    = rstn && adv && ((state == FIRST) || (state == BODY));
  assign ready_strip = rstn && (state == IDLE);
  assign beat_acc    = valid_in && ready_in;

  // Bytes outside keep are zeroed on entry so that every unused byte lane
  // of data_out falls out as zero from the shifts below.
  assign data_in_m   = data_in & byte_mask(keep_in);

  // The residue of the previous beat is its bytes S..BYTES-1, brought to the
  // top by shifting left S bytes; the head of the current beat (its first S
  // bytes) fills the remaining low lanes by shifting right BYTES-S bytes.
  assign head_shift  = SH_WD'({strip_q, 3'b000});
  assign tail_shift  = SH_WD'(DATA_WD) - head_shift;
  assign tail_cnt    = CW'(BYTES) - {1'b0, strip_q};
  assign body_data   = (prev_data << head_shift) | (data_in_m >> tail_shift);
  assign body_keep   = (prev_keep << strip_q) | (keep_in >> tail_cnt);

  // keep is MSB-contiguous, so after shifting out S enables the top bit is
  // still set exactly when the beat carried more than S bytes.
  assign keep_in_sh  = keep_in << strip_q;
  assign n_gt_s      = keep_in_sh[BYTES-1];

  // Next-state and next-output computation. Every registered value holds by
  // default; the output register is cleared whenever it advances and is then
  // overwritten by whichever state produces a beat this cycle.
  always_comb begin
    state_nxt     = state;
    strip_nxt     = strip_q;
    prev_data_nxt = prev_data;
    prev_keep_nxt = prev_keep;
    valid_nxt     = valid_out;
    data_nxt      = data_out;
    keep_nxt      = keep_out;
    last_nxt      = last_out;
    short_nxt     = 1'b0;

    if (adv) begin
      valid_nxt = 1'b0;
      data_nxt  = '0;
      keep_nxt  = '0;
      last_nxt  = 1'b0;
    end

    case (state)
      IDLE: begin
        if (valid_strip) begin
          strip_nxt = strip_cnt;
          state_nxt = FIRST;
        end
      end

      FIRST: begin
        if (beat_acc) begin
          prev_data_nxt = data_in_m;
          prev_keep_nxt = keep_in;
          if (last_in) begin
            state_nxt = IDLE;
            if (n_gt_s) begin
              valid_nxt = 1'b1;
              data_nxt  = data_in_m << head_shift;
              keep_nxt  = keep_in_sh;
              last_nxt  = 1'b1;
            end else begin
              short_nxt = 1'b1;
            end
          end else begin
            state_nxt = BODY;
          end
        end
      end

      BODY: begin
        if (beat_acc) begin
          valid_nxt     = 1'b1;
          data_nxt      = body_data;
          keep_nxt      = body_keep;
          last_nxt      = last_in && !n_gt_s;
          prev_data_nxt = data_in_m;
          prev_keep_nxt = keep_in;
          if (last_in) begin
            state_nxt = n_gt_s ? FLUSH : IDLE;
          end
        end
      end

      FLUSH: begin
        if (adv) begin
          valid_nxt = 1'b1;
          data_nxt  = prev_data << head_shift;
          keep_nxt  = prev_keep << strip_q;
          last_nxt  = 1'b1;
          state_nxt = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State, residue and output registers. Reset drops any partial packet.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= IDLE;
      strip_q   <= '0;
      prev_data <= '0;
      prev_keep <= '0;
      valid_out <= 1'b0;
      data_out  <= '0;
      keep_out  <= '0;
      last_out  <= 1'b0;
      short_pkt <= 1'b0;
    end else begin
      state     <= state_nxt;
      strip_q   <= strip_nxt;
      prev_data <= prev_data_nxt;
      prev_keep <= prev_keep_nxt;
      valid_out <= valid_nxt;
      data_out  <= data_nxt;
      keep_out  <= keep_nxt;
      last_out  <= last_nxt;
      short_pkt <= short_nxt;
    end
  end

`ifdef HDR_EXTRACT_EN
  logic [BYTES-1:0] hdr_keep_nxt;

  // The stripped header is the top S bytes of the first beat, limited to
  // bytes actually present when the packet is shorter than S.
  assign hdr_keep_nxt = ~({BYTES{1'b1}} >> strip_q) & keep_in;

  // Header capture is a side output with no backpressure: it pulses once
  // per packet, on the cycle after the first beat is accepted.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      hdr_valid <= 1'b0;
      hdr_data  <= '0;
      hdr_keep  <= '0;
    end else begin
      hdr_valid <= (state == FIRST) && beat_acc;
      if ((state == FIRST) && beat_acc) begin
        hdr_data <= data_in & byte_mask(hdr_keep_nxt);
        hdr_keep <= hdr_keep_nxt;
      end
    end
  end
`else
  // Without header extraction the stripped bytes are simply dropped.
`endif

endmodule

// File: tb/tb_axi_stream_strip_header.sv
// ---------------------------------------------------------------------------
// tb_axi_stream_strip_header
//
// Directed bench for axi_stream_strip_header with DATA_WD=32. Packets are
// driven beat by beat, output beats are collected by a monitor and compared
// against hand-computed expected beats.
// ---------------------------------------------------------------------------
module tb_axi_stream_strip_header;

  localparam int DATA_WD     = 32;
  localparam int BYTES       = DATA_WD / 8;
  localparam int BYTE_CNT_WD = $clog2(BYTES);
  localparam int TIMEOUT     = 200;

  logic                   clk;
  logic                   rstn;
  logic                   valid_in;
  logic [DATA_WD-1:0]     data_in;
  logic [BYTES-1:0]       keep_in;
  logic                   last_in;
  logic                   ready_in;
  logic                   valid_strip;
  logic [BYTE_CNT_WD-1:0] strip_cnt;
  logic                   ready_strip;
  logic                   valid_out;
  logic [DATA_WD-1:0]     data_out;
  logic [BYTES-1:0]       keep_out;
  logic                   last_out;
  logic                   ready_out;
  logic                   short_pkt;
`ifdef HDR_EXTRACT_EN
  logic                   hdr_valid;
  logic [DATA_WD-1:0]     hdr_data;
  logic [BYTES-1:0]       hdr_keep;
`endif

  int          checks;
  int          errors;
  int          short_count;
  logic [63:0] out_q[$];
  logic [63:0] exp_q[$];
  logic [31:0] pkt_data[7];
  logic [3:0]  pkt_keep[7];
  logic        stall_en;
  logic [6:0]  stall_pat;
  int          stall_idx;
  logic        stall_seen;
  logic [63:0] stall_val;
`ifdef HDR_EXTRACT_EN
  int          hdr_count;
  logic [63:0] hdr_last;
`endif

  axi_stream_strip_header #(
    .DATA_WD (DATA_WD)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .valid_in    (valid_in),
    .data_in     (data_in),
    .keep_in     (keep_in),
    .last_in     (last_in),
    .ready_in    (ready_in),
    .valid_strip (valid_strip),
    .strip_cnt   (strip_cnt),
    .ready_strip (ready_strip),
    .valid_out   (valid_out),
    .data_out    (data_out),
    .keep_out    (keep_out),
    .last_out    (last_out),
    .ready_out   (ready_out),
    .short_pkt   (short_pkt)
`ifdef HDR_EXTRACT_EN
    ,
    .hdr_valid   (hdr_valid),
    .hdr_data    (hdr_data),
    .hdr_keep    (hdr_keep)
`endif
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Downstream ready: always 1 unless the stall pattern is enabled.
  initial begin
    ready_out = 1'b1;
    stall_idx = 0;
    stall_pat = 7'b1001101;
    forever begin
      @(posedge clk);
      #1;
      if (stall_en) begin
        ready_out = stall_pat[stall_idx];
        stall_idx = (stall_idx + 1) % 7;
      end else begin
        ready_out = 1'b1;
      end
    end
  end

  task automatic check_output(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Output monitor: samples on the falling edge, records every handshaken
  // beat, checks that a stalled beat is held unchanged, counts short pulses.
  initial begin
    stall_seen = 1'b0;
    stall_val  = '0;
    forever begin
      @(negedge clk);
      if (rstn !== 1'b1) begin
        stall_seen = 1'b0;
      end else begin
        if (stall_seen) begin
          check_output("stall_hold", {26'd0, valid_out, last_out, keep_out, data_out}, stall_val);
        end
        stall_seen = valid_out && !ready_out;
        stall_val  = {26'd0, 1'b1, last_out, keep_out, data_out};
        if (valid_out && ready_out) begin
          out_q.push_back({27'd0, last_out, keep_out, data_out});
        end
        if (short_pkt) begin
          short_count++;
        end
`ifdef HDR_EXTRACT_EN
        if (hdr_valid) begin
          hdr_count++;
          hdr_last = {28'd0, hdr_keep, hdr_data};
        end
`endif
      end
    end
  end

  // Offers a strip command and waits (bounded) until it is taken.
  task automatic send_cmd(input logic [BYTE_CNT_WD-1:0] s);
    int n;
    n           = 0;
    valid_strip = 1'b1;
    strip_cnt   = s;
    @(negedge clk);
    while (ready_strip !== 1'b1 && n < TIMEOUT) begin
      @(negedge clk);
      n++;
    end
    check_output("cmd_handshake", {63'd0, ready_strip}, 64'd1);
    @(posedge clk);
    #1;
    valid_strip = 1'b0;
  endtask

  // Offers one input beat and waits (bounded) until it is accepted.
  task automatic apply_stimulus(input logic [31:0] d, input logic [3:0] k, input logic l);
    int n;
    n        = 0;
    valid_in = 1'b1;
    data_in  = d;
    keep_in  = k;
    last_in  = l;
    @(negedge clk);
    while (ready_in !== 1'b1 && n < TIMEOUT) begin
      @(negedge clk);
      n++;
    end
    check_output("beat_handshake", {63'd0, ready_in}, 64'd1);
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    last_in  = 1'b0;
  endtask

  task automatic send_packet(input logic [BYTE_CNT_WD-1:0] s);
    send_cmd(s);
    for (int i = 0; i < 7; i++) begin
      apply_stimulus(pkt_data[i], pkt_keep[i], (i == 6));
    end
  endtask

  // Waits (bounded) until the output is empty and the block is back in IDLE.
  task automatic drain(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!(valid_out === 1'b0 && ready_strip === 1'b1) && n < TIMEOUT) begin
      @(negedge clk);
      n++;
    end
    check_output({tag, "_drain"}, {62'd0, valid_out, ready_strip}, 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic exp_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
    exp_q.push_back({27'd0, l, k, d});
  endtask

  task automatic compare_packet(input string tag);
    check_output({tag, "_beats"}, 64'(out_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < out_q.size()) begin
        check_output($sformatf("%s_beat%0d", tag, i), out_q[i], exp_q[i]);
      end
    end
    out_q.delete();
    exp_q.delete();
  endtask

  task automatic load_exp_s1();
    exp_beat(32'hBBCC00AA, 4'hF, 1'b0);
    exp_beat(32'hBBCC01AA, 4'hF, 1'b0);
    exp_beat(32'hBBCC02AA, 4'hF, 1'b0);
    exp_beat(32'hBBCC03AA, 4'hF, 1'b0);
    exp_beat(32'hBBCC04AA, 4'hF, 1'b0);
    exp_beat(32'hBBCC05FF, 4'hF, 1'b0);
    exp_beat(32'hFF000000, 4'h8, 1'b1);
  endtask

  task automatic load_exp_s3();
    exp_beat(32'h00AABBCC, 4'hF, 1'b0);
    exp_beat(32'h01AABBCC, 4'hF, 1'b0);
    exp_beat(32'h02AABBCC, 4'hF, 1'b0);
    exp_beat(32'h03AABBCC, 4'hF, 1'b0);
    exp_beat(32'h04AABBCC, 4'hF, 1'b0);
    exp_beat(32'h05FFFF00, 4'hE, 1'b1);
  endtask

  // Directed sequence.
  initial begin
    checks      = 0;
    errors      = 0;
    short_count = 0;
    stall_en    = 1'b0;
`ifdef HDR_EXTRACT_EN
    hdr_count   = 0;
    hdr_last    = '0;
`endif
    rstn        = 1'b0;
    valid_in    = 1'b0;
    data_in     = '0;
    keep_in     = '0;
    last_in     = 1'b0;
    valid_strip = 1'b0;
    strip_cnt   = '0;
    for (int i = 0; i < 6; i++) begin
      pkt_data[i] = 32'hAABBCC00 + 32'(i);
      pkt_keep[i] = 4'hF;
    end
    pkt_data[6] = 32'hFFFF1234;
    pkt_keep[6] = 4'hC;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_output("reset_outputs",
                 {21'd0, short_pkt, ready_in, ready_strip, valid_out, last_out, keep_out, data_out},
                 64'd0);
    rstn = 1'b1;
    #1;
    check_output("reset_release_ready_strip", {63'd0, ready_strip}, 64'd1);
    @(posedge clk);
    #1;

    // Test 1: S=1
    $display("[TB] test 1: strip 1 byte");
    send_packet(2'd1);
    drain("t1");
    load_exp_s1();
    compare_packet("t1");
`ifdef HDR_EXTRACT_EN
    check_output("t1_hdr_count", 64'(hdr_count), 64'd1);
    check_output("t1_hdr", hdr_last, {28'd0, 4'b1000, 32'hAA000000});
`endif

    // Test 2: S=3
    $display("[TB] test 2: strip 3 bytes");
    send_packet(2'd3);
    drain("t2");
    load_exp_s3();
    compare_packet("t2");

    // Test 3: S=0 pass-through with one beat of latency
    $display("[TB] test 3: pass-through");
    send_cmd(2'd0);
    apply_stimulus(32'h11223344, 4'hF, 1'b0);
    check_output("t3_latency_first", {63'd0, valid_out}, 64'd0);
    apply_stimulus(32'h55667788, 4'hF, 1'b0);
    check_output("t3_latency_second", {27'd0, valid_out, keep_out, data_out},
                 {27'd0, 1'b1, 4'hF, 32'h11223344});
    apply_stimulus(32'h99AA0000, 4'hC, 1'b1);
    drain("t3");
    exp_beat(32'h11223344, 4'hF, 1'b0);
    exp_beat(32'h55667788, 4'hF, 1'b0);
    exp_beat(32'h99AA0000, 4'hC, 1'b1);
    compare_packet("t3");

    // Test 4: packet shorter than the strip count
    $display("[TB] test 4: short packet");
    send_cmd(2'd2);
    apply_stimulus(32'h12345678, 4'h8, 1'b1);
    check_output("t4_short_pulse", {62'd0, short_pkt, valid_out}, 64'd2);
    @(posedge clk);
    #1;
    check_output("t4_short_end", {62'd0, short_pkt, ready_strip}, 64'd1);
    drain("t4");
    check_output("t4_short_count", 64'(short_count), 64'd1);
    compare_packet("t4");

    // Test 5: test 1 packet under downstream backpressure
    $display("[TB] test 5: backpressure");
    stall_en = 1'b1;
    send_packet(2'd1);
    drain("t5");
    stall_en = 1'b0;
    load_exp_s1();
    compare_packet("t5");

    // Test 6: reset in the middle of a packet, then a clean packet
    $display("[TB] test 6: mid-packet reset");
    send_cmd(2'd1);
    apply_stimulus(pkt_data[0], pkt_keep[0], 1'b0);
    apply_stimulus(pkt_data[1], pkt_keep[1], 1'b0);
    apply_stimulus(pkt_data[2], pkt_keep[2], 1'b0);
    rstn = 1'b0;
    @(posedge clk);
    #1;
    check_output("t6_reset_outputs",
                 {21'd0, short_pkt, ready_in, ready_strip, valid_out, last_out, keep_out, data_out},
                 64'd0);
    rstn = 1'b1;
    #1;
    check_output("t6_release", {62'd0, ready_strip, ready_in}, 64'd2);
    out_q.delete();
    send_packet(2'd3);
    drain("t6");
    load_exp_s3();
    compare_packet("t6");
    check_output("final_short_count", 64'(short_count), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
